// File: rtl/playfield_scanner.sv
// playfield_scanner: raster position -> board cell / pixel-in-cell tracker,
// board RAM read and piece palette lookup, three registered stages deep.
// Optional build macro PLAYFIELD_GRID_EN: empty cells inside the field show
// a faint 12'h111 instead of black.
module playfield_scanner #(
    parameter int COLS   = 10,
    parameter int ROWS   = 15,
    parameter int CELL_W = 26,
    parameter int CELL_H = 32,
    parameter int X0     = 190,
    parameter int Y0     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_active,
    output logic        board_rd,
    output logic [7:0]  board_addr,
    input  logic [2:0]  board_data,
    output logic [5:0]  block_x,
    output logic [5:0]  block_y,
    output logic [11:0] in_color,
    output logic        in_field,
    output logic        out_active
);

    localparam logic [5:0] SUBX_LAST = 6'(CELL_W - 1);
    localparam logic [5:0] SUBY_LAST = 6'(CELL_H - 1);
    localparam logic [7:0] COL_LAST  = 8'(COLS - 1);
    localparam logic [7:0] ROW_LAST  = 8'(ROWS - 1);
    localparam logic [7:0] COLS_V    = 8'(COLS);
    localparam logic [9:0] X0_V      = 10'(X0);
    localparam logic [9:0] Y0_V      = 10'(Y0);

`ifdef PLAYFIELD_GRID_EN
    localparam logic [11:0] EMPTY_COLOR = 12'h111;
`else
    localparam logic [11:0] EMPTY_COLOR = 12'h000;
`endif

    // Position counters: _q is the position of the previous pixel, _d of the current one
    logic [5:0] sub_x_q, sub_x_d;
    logic [7:0] col_q, col_d;
    logic       in_x_q, in_x_d;
    logic [5:0] sub_y_q, sub_y_d;
    logic [7:0] row_q, row_d;
    logic       in_y_q, in_y_d;
    logic       active_q;

    logic       field_d;
    logic       fall_d;
    logic [7:0] addr_d;

    // Stage 1 and stage 2 carried values
    logic       rd_q;
    logic [7:0] addr_q;
    logic [5:0] s1_sub_x_q, s1_sub_y_q;
    logic       s1_active_q;
    logic [5:0] s2_sub_x_q, s2_sub_y_q;
    logic       s2_field_q, s2_active_q;

    // Output stage
    logic [5:0]  block_x_q, block_y_q;
    logic [11:0] color_q;
    logic        field_q, out_active_q;

    function automatic logic [11:0] palette(input logic [2:0] code);
        logic [11:0] c;
        c = EMPTY_COLOR;
        case (code)
            3'd1: c = 12'h0FF;
            3'd2: c = 12'hFF0;
            3'd3: c = 12'hA0F;
            3'd4: c = 12'h0F0;
            3'd5: c = 12'hF00;
            3'd6: c = 12'h00F;
            3'd7: c = 12'hF80;
            default: c = EMPTY_COLOR;
        endcase
        return c;
    endfunction

    // Horizontal position: load at the field's left edge, step on every active pixel
    always_comb begin
        sub_x_d = sub_x_q;
        col_d   = col_q;
        in_x_d  = in_x_q;
        if (pix_active && pix_x == X0_V) begin
            sub_x_d = 6'd0;
            col_d   = 8'd0;
            in_x_d  = 1'b1;
        end else if (pix_active && in_x_q) begin
            if (sub_x_q == SUBX_LAST) begin
                sub_x_d = 6'd0;
                if (col_q == COL_LAST) begin
                    col_d  = 8'd0;
                    in_x_d = 1'b0;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end else begin
                sub_x_d = sub_x_q + 6'd1;
            end
        end
    end

    // Vertical position: load on the first pixel of line Y0, step on each end of line
    always_comb begin
        fall_d  = active_q & ~pix_active;
        sub_y_d = sub_y_q;
        row_d   = row_q;
        in_y_d  = in_y_q;
        if (pix_active && pix_y == Y0_V && pix_x == 10'd0) begin
            sub_y_d = 6'd0;
            row_d   = 8'd0;
            in_y_d  = 1'b1;
        end else if (fall_d && in_y_q) begin
            if (sub_y_q == SUBY_LAST) begin
                sub_y_d = 6'd0;
                if (row_q == ROW_LAST) begin
                    row_d  = 8'd0;
                    in_y_d = 1'b0;
                end else begin
                    row_d = row_q + 8'd1;
                end
            end else begin
                sub_y_d = sub_y_q + 6'd1;
            end
        end
    end

    // Field membership and cell address of the current pixel (address truncates to 8 bits)
    always_comb begin
        field_d = in_x_d & in_y_d & pix_active;
        addr_d  = row_d * COLS_V + col_d;
    end

    // Counters plus the three pipeline stages; everything outside the field is forced to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_x_q      <= '0;
            col_q        <= '0;
            in_x_q       <= 1'b0;
            sub_y_q      <= '0;
            row_q        <= '0;
            in_y_q       <= 1'b0;
            active_q     <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            s1_sub_x_q   <= '0;
            s1_sub_y_q   <= '0;
            s1_active_q  <= 1'b0;
            s2_sub_x_q   <= '0;
            s2_sub_y_q   <= '0;
            s2_field_q   <= 1'b0;
            s2_active_q  <= 1'b0;
            block_x_q    <= '0;
            block_y_q    <= '0;
            color_q      <= '0;
            field_q      <= 1'b0;
            out_active_q <= 1'b0;
        end else begin
            sub_x_q      <= sub_x_d;
            col_q        <= col_d;
            in_x_q       <= in_x_d;
            sub_y_q      <= sub_y_d;
            row_q        <= row_d;
            in_y_q       <= in_y_d;
            active_q     <= pix_active;

            rd_q         <= field_d;
            addr_q       <= field_d ? addr_d : 8'd0;
            s1_sub_x_q   <= field_d ? sub_x_d : 6'd0;
            s1_sub_y_q   <= field_d ? sub_y_d : 6'd0;
            s1_active_q  <= pix_active;

            s2_sub_x_q   <= s1_sub_x_q;
            s2_sub_y_q   <= s1_sub_y_q;
            s2_field_q   <= rd_q;
            s2_active_q  <= s1_active_q;

            block_x_q    <= s2_sub_x_q;
            block_y_q    <= s2_sub_y_q;
            color_q      <= s2_field_q ? palette(board_data) : 12'h000;
            field_q      <= s2_field_q;
            out_active_q <= s2_active_q;
        end
    end

    assign board_rd   = rd_q;
    assign board_addr = addr_q;
    assign block_x    = block_x_q;
    assign block_y    = block_y_q;
    assign in_color   = color_q;
    assign in_field   = field_q;
    assign out_active = out_active_q;

endmodule

// File: tb/tb_playfield_scanner.sv
// Scoreboard bench for playfield_scanner: a directed raster drives the DUT,
// hand-computed expectations for selected pixels are queued with the cycle
// they are due, and a monitor on the falling edge pops and compares them.
module tb_playfield_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        pix_active = 1'b0;
    logic        board_rd;
    logic [7:0]  board_addr;
    logic [2:0]  board_data = '0;
    logic [5:0]  block_x, block_y;
    logic [11:0] in_color;
    logic        in_field, out_active;

    always #5 clk = ~clk;

    playfield_scanner dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_active(pix_active),
        .board_rd(board_rd), .board_addr(board_addr), .board_data(board_data),
        .block_x(block_x), .block_y(block_y), .in_color(in_color),
        .in_field(in_field), .out_active(out_active)
    );

`ifdef PLAYFIELD_GRID_EN
    localparam logic [11:0] EMPTY = 12'h111;
`else
    localparam logic [11:0] EMPTY = 12'h000;
`endif

    // Board RAM model: synchronous read, data valid the cycle after board_rd
    logic [2:0] board_mem [0:255];
    always @(posedge clk) if (board_rd) board_data <= board_mem[board_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x; int y; bit f; int bx; int by; logic [11:0] col; int addr;
    } vec_t;
    typedef struct {
        int due; int x; int y; bit f; logic [5:0] bx; logic [5:0] by; logic [11:0] col; bit act;
    } out_t;
    typedef struct {
        int due; int x; int y; bit rd; logic [7:0] addr;
    } rd_t;

    vec_t vecs[$];
    out_t q_out[$];
    rd_t  q_rd[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Monitor: compare every queued expectation in the cycle it falls due
    out_t eo;
    rd_t  er;
    always @(negedge clk) begin
        while (q_out.size() > 0 && q_out[0].due <= cyc) begin
            eo = q_out.pop_front();
            n_chk++;
            if (eo.due < cyc)
                $display("FAIL out(%0d,%0d) missed its cycle %0d", eo.x, eo.y, eo.due);
            else if (in_field == eo.f && block_x == eo.bx && block_y == eo.by &&
                     in_color == eo.col && out_active == eo.act)
                n_pass++;
            else
                $display("FAIL out(%0d,%0d) got f=%0b bx=%0d by=%0d col=%h act=%0b want f=%0b bx=%0d by=%0d col=%h act=%0b",
                         eo.x, eo.y, in_field, block_x, block_y, in_color, out_active,
                         eo.f, eo.bx, eo.by, eo.col, eo.act);
        end
        while (q_rd.size() > 0 && q_rd[0].due <= cyc) begin
            er = q_rd.pop_front();
            n_chk++;
            if (er.due < cyc)
                $display("FAIL rd(%0d,%0d) missed its cycle %0d", er.x, er.y, er.due);
            else if (board_rd == er.rd && (!er.rd || board_addr == er.addr))
                n_pass++;
            else
                $display("FAIL rd(%0d,%0d) got rd=%0b addr=%0d want rd=%0b addr=%0d",
                         er.x, er.y, board_rd, board_addr, er.rd, er.addr);
        end
    end

    task automatic add_vec(input int x, input int y, input bit f, input int bx, input int by,
                           input logic [11:0] col, input int addr);
        vec_t v;
        v.x = x; v.y = y; v.f = f; v.bx = bx; v.by = by; v.col = col; v.addr = addr;
        vecs.push_back(v);
    endtask

    task automatic drive(input int x, input int y, input bit act);
        out_t o;
        rd_t  r;
        @(negedge clk);
        rst = 1'b0; pix_x = 10'(x); pix_y = 10'(y); pix_active = act;
        if (act) begin
            foreach (vecs[i]) begin
                if (vecs[i].x == x && vecs[i].y == y) begin
                    o.due = cyc + 3; o.x = x; o.y = y; o.f = vecs[i].f;
                    o.bx = 6'(vecs[i].bx); o.by = 6'(vecs[i].by); o.col = vecs[i].col; o.act = 1'b1;
                    q_out.push_back(o);
                    r.due = cyc + 1; r.x = x; r.y = y; r.rd = vecs[i].f; r.addr = 8'(vecs[i].addr);
                    q_rd.push_back(r);
                end
            end
        end
    endtask

    // Pixel presented with reset asserted: everything must read 0 the next cycle
    task automatic drive_rst(input int x, input int y, input bit act);
        out_t o;
        rd_t  r;
        @(negedge clk);
        rst = 1'b1; pix_x = 10'(x); pix_y = 10'(y); pix_active = act;
        o.due = cyc + 1; o.x = x; o.y = y; o.f = 1'b0; o.bx = '0; o.by = '0; o.col = '0; o.act = 1'b0;
        q_out.push_back(o);
        r.due = cyc + 1; r.x = x; r.y = y; r.rd = 1'b0; r.addr = '0;
        q_rd.push_back(r);
    endtask

    task automatic blank(input int y);
        for (int i = 0; i < 20; i++) drive(700, y, 1'b0);
    endtask

    task automatic full_line(input int y);
        for (int x = 0; x < 640; x++) drive(x, y, 1'b1);
        blank(y);
    endtask

    // Abbreviated line: one active pixel is enough to produce the falling edge
    task automatic short_line(input int y);
        drive(0, y, 1'b1);
        drive(700, y, 1'b0);
        drive(700, y, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) board_mem[i] = 3'd1;
        board_mem[0] = 3'd3; board_mem[1] = 3'd2; board_mem[9] = 3'd7;
        board_mem[10] = 3'd6; board_mem[23] = 3'd0; board_mem[149] = 3'd5;

        add_vec(189, 0,   0, 0,  0,  12'h000, 0);
        add_vec(190, 0,   1, 0,  0,  12'hA0F, 0);
        add_vec(215, 0,   1, 25, 0,  12'hA0F, 0);
        add_vec(216, 0,   1, 0,  0,  12'hFF0, 1);
        add_vec(449, 0,   1, 25, 0,  12'hF80, 9);
        add_vec(450, 0,   0, 0,  0,  12'h000, 0);
        add_vec(190, 31,  1, 0,  31, 12'hA0F, 0);
        add_vec(190, 32,  1, 0,  0,  12'h00F, 10);
        add_vec(268, 64,  1, 0,  0,  EMPTY,   23);
        add_vec(293, 64,  1, 25, 0,  EMPTY,   23);
        add_vec(449, 479, 1, 25, 31, 12'hF00, 149);
        add_vec(190, 480, 0, 0,  0,  12'h000, 0);
        add_vec(449, 480, 0, 0,  0,  12'h000, 0);
        add_vec(250, 40,  1, 8,  8,  12'h0FF, 12);
        add_vec(350, 40,  0, 0,  0,  12'h000, 0);
        add_vec(190, 41,  0, 0,  0,  12'h000, 0);

        // Power-on reset
        for (int i = 0; i < 3; i++) drive_rst(0, 0, 1'b0);

        // Frame 0: full lines where checks live, abbreviated lines elsewhere
        full_line(0);
        for (int y = 1; y < 31; y++) short_line(y);
        full_line(31);
        full_line(32);
        for (int y = 33; y < 64; y++) short_line(y);
        full_line(64);
        for (int y = 65; y < 479; y++) short_line(y);
        full_line(479);
        full_line(480);

        // Frame 1: reset in the middle of line 40
        for (int y = 0; y < 40; y++) short_line(y);
        for (int x = 0; x < 300; x++) drive(x, 40, 1'b1);
        drive_rst(300, 40, 1'b1);
        for (int x = 301; x < 640; x++) drive(x, 40, 1'b1);
        blank(40);
        full_line(41);

        // Frame 2: field comes back at line Y0
        full_line(0);

        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
